serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder: the addition counterpart of the team's subtractor cells.
- Loads two WIDTH-bit operands plus carry-in on a start pulse and resolves one bit per clock through a single registered full-adder slice.
- Presents the sum and carry-out with a one-cycle done pulse.
- Sits in the arithmetic datapath as an area-minimal adder for multi-cycle operations.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and bit counter are also 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - Full-adder slice on (a_sr[0], b_sr[0], carry) gives s and c.
  - carry<=c; a_sr and b_sr shift right by 1; sum_sr<={s, sum_sr[WIDTH-1:1]}; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH):
    - sum<={s, sum_sr[WIDTH-1:1]} and cout<=c;
    - state goes to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - busy is high in cycles E0..E_WIDTH (WIDTH cycles).
  - done is high in the cycle after edge E_WIDTH.
  - Start-to-done is WIDTH edges; throughput is one operation per WIDTH+2 cycles.
- Output stability: sum and cout change only on the edge entering DONE. They hold their previous value throughout RUN and indefinitely after DONE until the next completion.
- Ignored inputs:
  - start in RUN or DONE is ignored; it is not queued.
  - Changes on a, b and cin after capture have no effect on the operation in flight.
- Reset mid-operation: immediately aborts to IDLE with all reset values. No done pulse occurs, and the partial result is discarded.
- Width rules:
  - cnt is $clog2(WIDTH+1) bits wide.
  - The result is the exact WIDTH+1-bit value {cout, sum} = a+b+cin.
- WIDTH=1: RUN lasts one edge; the behaviour is identical to a registered full adder plus handshake.

Decomposition:
- Shared package adder_pkg:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - WIDTH legal-range constants MIN_WIDTH=1 and MAX_WIDTH=32.
- One natural sub-module, fulladder:
  - combinational slice built from two halfadder instances plus OR;
  - ports a, b, cin, sum, cout;
  - instantiated once per serial_adder.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse at E0:
  - busy high for 8 cycles;
  - done pulses one cycle after E8;
  - sum=0x96, cout=0;
  - sum stays at its old value during RUN.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Hold start high continuously with changing a and b:
  - only the first request is accepted; operands change during RUN without effect;
  - the next accept occurs in the first IDLE cycle after DONE;
  - done pulses exactly once per operation.
- Assert rst at the 4th RUN cycle of a=0x12, b=0x34:
  - outputs go immediately to 0 and state to IDLE;
  - no done pulse;
  - a fresh start with a=0x01, b=0x02 yields sum=0x03, cout=0.
- WIDTH=1:
  - a=1, b=1, cin=1 -> sum=1, cout=1;
  - done one cycle after the single RUN edge.
- Randomised sweep of 1000 operations at WIDTH=8 and WIDTH=32, compared against {cout, sum} == a+b+cin.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e   : controller state encoding (idle, running, result presentation)
//   MIN_WIDTH : smallest supported operand width
//   MAX_WIDTH : largest supported operand width
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MIN_WIDTH = 1;
    localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder built from two half adders and an OR.
//   a, b : addend bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : carry out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s0),
        .cout (c0)
    );

    halfadder u_ha1 (
        .a    (s0),
        .b    (cin),
        .sum  (sum),
        .cout (c1)
    );

    // Both half-adder carries can never be high together.
    assign cout = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// Single-bit half adder.
//   a, b : addend bits
//   sum  : a ^ b
//   cout : a & b
module halfadder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice resolves one bit per clock.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, sampled only when idle
//   a, b  : operands, captured on accepted start
//   cin   : carry in, captured on accepted start
//   busy  : high while bits are being resolved
//   done  : one-cycle pulse, sum/cout valid from this cycle
//   sum   : registered (a + b + cin) mod 2^WIDTH
//   cout  : registered carry out of the MSB
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    if (WIDTH == 1) begin : g_w1
        assign sum_sr_next = fa_s;
    end else begin : g_wn
        assign sum_sr_next = {fa_s, sum_sr[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    carry_q <= fa_c;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_sr_next;
                    cnt_q   <= cnt_q + 1'b1;
                    // Result registers only move on the final bit.
                    if (cnt_q == CNT_LAST) begin
                        sum_q  <= sum_sr_next;
                        cout_q <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 32.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
    logic [0:0]  a1 = '0, b1 = '0, sum1;
    logic        start32 = 1'b0, cin32 = 1'b0, busy32, done32, cout32;
    logic [31:0] a32 = '0, b32 = '0, sum32;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst), .start (start8), .a (a8), .b (b8), .cin (cin8),
        .busy (busy8), .done (done8), .sum (sum8), .cout (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst), .start (start1), .a (a1), .b (b1), .cin (cin1),
        .busy (busy1), .done (done1), .sum (sum1), .cout (cout1)
    );

    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk (clk), .rst (rst), .start (start32), .a (a32), .b (b32), .cin (cin32),
        .busy (busy32), .done (done32), .sum (sum32), .cout (cout32)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected contents of the 8-bit result registers between operations.
    logic [7:0] last_sum8  = '0;
    logic       last_cout8 = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation with latency, hold and done-pulse checks.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es, input logic ec);
        int busy_cycles;
        bit got_done;
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        // Disturb the inputs after capture.
        a8 = ~a; b8 = ~b; cin8 = ~ci;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (done8) begin
                got_done = 1'b1;
            end else begin
                if (busy8) busy_cycles++;
                check({tag, " sum hold"}, 64'(sum8), 64'(last_sum8));
                check({tag, " cout hold"}, 64'(cout8), 64'(last_cout8));
                tick();
            end
        end
        check({tag, " done seen"}, 64'(got_done), 64'd1);
        check({tag, " busy cycles"}, 64'(busy_cycles), 64'd8);
        check({tag, " busy in done"}, 64'(busy8), 64'd0);
        check({tag, " sum"}, 64'(sum8), 64'(es));
        check({tag, " cout"}, 64'(cout8), 64'(ec));
        last_sum8 = es;
        last_cout8 = ec;
        tick();
        check({tag, " done pulse width"}, 64'(done8), 64'd0);
        check({tag, " sum after done"}, 64'(sum8), 64'(es));
    endtask

    task automatic op1(input string tag, input logic a, input logic b, input logic ci,
                       input logic es, input logic ec, input logic old_s, input logic old_c);
        a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, " busy"}, 64'(busy1), 64'd1);
        check({tag, " no early done"}, 64'(done1), 64'd0);
        check({tag, " sum hold"}, 64'(sum1), 64'(old_s));
        check({tag, " cout hold"}, 64'(cout1), 64'(old_c));
        tick();
        check({tag, " done"}, 64'(done1), 64'd1);
        check({tag, " busy off"}, 64'(busy1), 64'd0);
        check({tag, " sum"}, 64'(sum1), 64'(es));
        check({tag, " cout"}, 64'(cout1), 64'(ec));
        tick();
        check({tag, " done cleared"}, 64'(done1), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        logic exp_busy;
        logic exp_done;
        logic [7:0]  ra8, rb8, s8;
        logic [31:0] ra32, rb32, s32;
        logic        rc8, rc32, c8, c32;
        logic [8:0]  e8;
        logic [32:0] e32;
        bit          g8, g32;
        int          guard;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset sum", 64'(sum8), 64'd0);
        check("reset cout", 64'(cout8), 64'd0);
        check("reset sum32", 64'(sum32), 64'd0);
        rst = 1'b0;
        tick();

        // Directed 8-bit vectors
        op8("5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        op8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start held high with operands changing every cycle
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            start8 = 1'b1;
            a8 = 8'h10 + 8'(k);
            b8 = 8'h20 + 8'(k);
            cin8 = 1'b0;
            tick();
            exp_busy = (k <= 7) || (k >= 10 && k <= 17);
            exp_done = (k == 8) || (k == 18);
            check($sformatf("held start busy k=%0d", k), 64'(busy8), 64'(exp_busy));
            check($sformatf("held start done k=%0d", k), 64'(done8), 64'(exp_done));
            if (done8) done_cnt++;
            if (k == 8)  check("held start sum op1", 64'(sum8), 64'h30);
            if (k == 18) check("held start sum op2", 64'(sum8), 64'h44);
        end
        start8 = 1'b0;
        check("held start done count", 64'(done_cnt), 64'd2);
        last_sum8 = 8'h44;
        last_cout8 = 1'b0;
        tick();

        // Reset during the 4th RUN cycle
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid reset busy", 64'(busy8), 64'd0);
        check("mid reset done", 64'(done8), 64'd0);
        check("mid reset sum", 64'(sum8), 64'd0);
        check("mid reset cout", 64'(cout8), 64'd0);
        tick();
        rst = 1'b0;
        last_sum8 = '0;
        last_cout8 = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8 || busy8) done_cnt++;
        end
        check("no activity after abort", 64'(done_cnt), 64'd0);
        op8("01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // WIDTH = 1
        op1("w1 1+1+1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        op1("w1 0+1+0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Random sweep, WIDTH = 8 and 32 side by side
        for (int n = 0; n < 1000; n++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rc8 = 1'($urandom);
            ra32 = $urandom; rb32 = $urandom; rc32 = 1'($urandom);
            if (n == 0) begin
                ra32 = 32'hFFFF_FFFF; rb32 = 32'h0; rc32 = 1'b1;
            end
            a8 = ra8; b8 = rb8; cin8 = rc8; start8 = 1'b1;
            a32 = ra32; b32 = rb32; cin32 = rc32; start32 = 1'b1;
            tick();
            start8 = 1'b0;
            start32 = 1'b0;
            a8 = $urandom; b8 = $urandom; a32 = $urandom; b32 = $urandom;
            g8 = 1'b0; g32 = 1'b0; s8 = '0; c8 = 1'b0; s32 = '0; c32 = 1'b0;
            guard = 0;
            while (!(g8 && g32) && guard < 60) begin
                if (done8)  begin g8 = 1'b1;  s8 = sum8;   c8 = cout8;   end
                if (done32) begin g32 = 1'b1; s32 = sum32; c32 = cout32; end
                if (!(g8 && g32)) tick();
                guard++;
            end
            e8 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc8};
            e32 = {1'b0, ra32} + {1'b0, rb32} + {32'd0, rc32};
            check($sformatf("rand8 #%0d done", n), 64'(g8), 64'd1);
            check($sformatf("rand8 #%0d result", n), 64'({c8, s8}), 64'(e8));
            check($sformatf("rand32 #%0d done", n), 64'(g32), 64'd1);
            check($sformatf("rand32 #%0d result", n), 64'({c32, s32}), 64'(e32));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
